// File: rtl/softmax_argmax.sv
// Top-1/top-2 selector for a ten-entry fp32 probability frame, scanned one entry per cycle.
// Values are ordered through a monotonic unsigned key, so no floating-point compare is needed.
module softmax_argmax #(
  parameter logic [31:0] THRESH = 32'h3F000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_in,
  input  logic [31:0] percent0,
  input  logic [31:0] percent1,
  input  logic [31:0] percent2,
  input  logic [31:0] percent3,
  input  logic [31:0] percent4,
  input  logic [31:0] percent5,
  input  logic [31:0] percent6,
  input  logic [31:0] percent7,
  input  logic [31:0] percent8,
  input  logic [31:0] percent9,
  output logic        busy,
  output logic [3:0]  class_idx,
  output logic [31:0] max_prob,
  output logic [3:0]  second_idx,
  output logic [31:0] second_prob,
  output logic        low_conf,
  output logic        valid_out,
  output logic        err_drop
);

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  state_t      state, state_next;
  logic [31:0] frame [10];
  logic [3:0]  cnt;
  logic [31:0] best_val, sec_val;
  logic [3:0]  best_idx, sec_idx;
  logic        sec_valid;
  logic [31:0] cand_val, cand_key;

  // Positive values get the top bit set; negative magnitudes are inverted so larger means greater.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? {1'b0, ~x[30:0]} : {1'b1, x[30:0]};
  endfunction

  assign busy     = (state != IDLE);
  assign cand_val = frame[cnt];
  assign cand_key = order_key(cand_val);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_in) state_next = SCAN;
      SCAN:    if (cnt == 4'd9) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      best_val    <= 32'd0;
      best_idx    <= 4'd0;
      sec_val     <= 32'd0;
      sec_idx     <= 4'd0;
      sec_valid   <= 1'b0;
      class_idx   <= 4'd0;
      max_prob    <= 32'd0;
      second_idx  <= 4'd0;
      second_prob <= 32'd0;
      low_conf    <= 1'b0;
      valid_out   <= 1'b0;
      err_drop    <= 1'b0;
      for (int i = 0; i < 10; i++) frame[i] <= 32'd0;
    end else begin
      state     <= state_next;
      valid_out <= 1'b0;
      if (valid_in && busy) err_drop <= 1'b1;
      case (state)
        // capture stage: frame buffer loaded, entry 0 seeds the best slot
        IDLE: if (valid_in) begin
          frame[0] <= percent0;
          frame[1] <= percent1;
          frame[2] <= percent2;
          frame[3] <= percent3;
          frame[4] <= percent4;
          frame[5] <= percent5;
          frame[6] <= percent6;
          frame[7] <= percent7;
          frame[8] <= percent8;
          frame[9] <= percent9;
          best_val  <= percent0;
          best_idx  <= 4'd0;
          sec_valid <= 1'b0;
          cnt       <= 4'd1;
        end
        // scan stage: strict greater-than keeps the lower index on ties
        SCAN: begin
          if (cand_key > order_key(best_val)) begin
            sec_val   <= best_val;
            sec_idx   <= best_idx;
            sec_valid <= 1'b1;
            best_val  <= cand_val;
            best_idx  <= cnt;
          end else if (!sec_valid || (cand_key > order_key(sec_val))) begin
            sec_val   <= cand_val;
            sec_idx   <= cnt;
            sec_valid <= 1'b1;
          end
          cnt <= cnt + 4'd1;
        end
        // output stage: results registered and held until the next frame completes
        OUT: begin
          class_idx   <= best_idx;
          max_prob    <= best_val;
          second_idx  <= sec_idx;
          second_prob <= sec_val;
          low_conf    <= (order_key(best_val) < order_key(THRESH));
          valid_out   <= 1'b1;
          cnt         <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/softmax_argmax.md
# softmax_argmax

Classification result stage placed directly after the softmax block. It takes one frame of ten IEEE-754 single-precision probabilities on a single-cycle valid pulse. It scans the frame sequentially, one comparison per cycle, and reports the top-1 and top-2 class indices and probabilities plus a low-confidence flag. The result is presented with a single-cycle valid pulse and held until the next result.

## Interface

Parameters:
- `THRESH`, default 32'h3F000000 (0.5): fp32 confidence threshold; `low_conf` is set when the top probability is below it.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  single-cycle frame strobe from softmax.
- `percent0`..`percent9`  in  32 each  fp32 probabilities; sampled only on the accepting edge.
- `busy`  out  1  high while a frame is being processed (state != IDLE).
- `class_idx`  out  4  index 0..9 of the largest probability.
- `max_prob`  out  32  fp32 value at `class_idx`.
- `second_idx`  out  4  index of the second-largest probability.
- `second_prob`  out  32  fp32 value at `second_idx`.
- `low_conf`  out  1  1 when `max_prob` is below `THRESH` in the ordering defined below.
- `valid_out`  out  1  one-cycle pulse; result outputs are updated on the same edge that raises it.
- `err_drop`  out  1  sticky; set when `valid_in` arrives while `busy` is high; cleared only by reset.

## Operation

- Ordering key: a 32-bit unsigned key `k(x)` is derived from each fp32 value `x`.
  - If `x[31]=0`: `k = {1'b1, x[30:0]}`.
  - If `x[31]=1`: `k = {1'b0, ~x[30:0]}`.
  - All comparisons are unsigned comparisons of keys. This gives true numeric order for all non-NaN values, with -0 ordered below +0. NaNs need no special handling.
- Input capture: all ten inputs are registered into an internal frame buffer on the accepting edge. Input values outside that edge are ignored.
- State machine:
  - IDLE: if `valid_in`=1, capture the frame; set best = (p0, idx 0); clear second_valid; set cnt = 1; go to SCAN.
  - SCAN: compare candidate `k(p[cnt])` against the current best and second.
    - If `k > k(best)`: second <= best, second_valid <= 1, best <= candidate.
    - Else if `!second_valid` or `k > k(second)`: second <= candidate, second_valid <= 1.
    - Increment cnt. When cnt = 9 is processed, go to OUT.
  - OUT: register `class_idx`, `max_prob`, `second_idx`, `second_prob` and `low_conf = (k(best) < k(THRESH))`; pulse `valid_out`; return to IDLE.
- Ties: replacement uses strict greater-than only, so the lower index wins for both best and second.
- `valid_in` during SCAN or OUT: the pulse is dropped, `err_drop` is set, and the frame in progress is unaffected.
- Result outputs hold their values between `valid_out` pulses.
- Reset (asynchronous, any time, including mid-SCAN):
  - State returns to IDLE and cnt = 0.
  - `busy`, `valid_out`, `low_conf` and `err_drop` go to 0.
  - `class_idx`, `second_idx`, `max_prob`, `second_prob` and the frame buffer go to 0.
  - An aborted frame never produces `valid_out`.

## Timing

- Edge 0: `valid_in` sampled high in IDLE. `busy` is high from after edge 0.
- Edges 1..9: SCAN processes indices 1..9.
- Edge 10: OUT registers the results. `valid_out` is high for exactly the cycle between edges 10 and 11.
- Latency: 10 cycles from the accepting edge to `valid_out`.
- `busy` is high from after edge 0 through edge 10 and falls after edge 10.
- The earliest next accepted `valid_in` is at edge 11, giving a throughput of one frame per 11 cycles.
- `valid_in` coincident with the edge that enters OUT (edge 9) or with OUT itself (edge 10) counts as a drop.
- Reset deassertion: the first accepting edge is the first rising edge with `resetn`=1.

## Test plan

- **One-hot frame:** `percent3`=32'h3F800000, all others 0. Required: `class_idx`=3, `max_prob`=32'h3F800000, `second_idx`=0, `second_prob`=0, `low_conf`=0, `valid_out` exactly 10 cycles after `valid_in`.
- **All ties:** all inputs 32'h3DCCCCCD (0.1). Required: `class_idx`=0, `second_idx`=1, `low_conf`=1.
- **Typical and negative inputs:**
  - p7=32'h3F333333 (0.7), p2=32'h3E4CCCCD (0.2), others 32'h3C23D70A. Required: `class_idx`=7, `second_idx`=2, `low_conf`=0.
  - p0=32'hBF800000 (-1.0), others 0. Required: `class_idx`=1, `second_idx`=2.
- **Overlapping frame:** a second `valid_in` at edge 5 with different data. Required: result reflects the first frame only, `err_drop`=1 and remains 1, exactly one `valid_out`.
- **Reset mid-scan:** `resetn` low at cycle 5. Required: all outputs 0 immediately, no `valid_out`; the next frame after release produces a correct result 10 cycles after acceptance.
- **Back-to-back frames:** second `valid_in` at edge 11. Required: accepted, `err_drop` stays 0, `valid_out` at cycles 10 and 21 with the respective correct results.
